// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - handshake and strobe bundle between start control, conv_seq_ctrl and the conversion datapath
//
// Optional feature macro: CTRL_ABORT_EN (adds the abort request line).
//
// Signals:
//   start       run request (falling edge after being seen high in IDLE launches a run)
//   data_valid  source word ready, only looked at while reading
//   abort       synchronous run cancel (CTRL_ABORT_EN builds only)
//   clr         datapath clear, high while idle
//   read_data   high throughout every read cycle
//   store_num   store strobe
//   en_cnt      sample counter enable strobe
//   write_file  result write strobe, once per run
//   done        one-cycle completion pulse
//   busy        high whenever a run is in progress
//   sample_idx  index of the sample being processed
//
// Modports:
//   master  start control / source side (drives requests, observes strobes)
//   slave   the sequencing controller
interface conv_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             data_valid;
`ifdef CTRL_ABORT_EN
    logic             abort;
`endif
    logic             clr;
    logic             read_data;
    logic             store_num;
    logic             en_cnt;
    logic             write_file;
    logic             done;
    logic             busy;
    logic [CNT_W-1:0] sample_idx;

`ifdef CTRL_ABORT_EN
    modport master (
        output start, data_valid, abort,
        input  clr, read_data, store_num, en_cnt, write_file, done, busy, sample_idx
    );

    modport slave (
        input  start, data_valid, abort,
        output clr, read_data, store_num, en_cnt, write_file, done, busy, sample_idx
    );
`else
    modport master (
        output start, data_valid,
        input  clr, read_data, store_num, en_cnt, write_file, done, busy, sample_idx
    );

    modport slave (
        input  start, data_valid,
        output clr, read_data, store_num, en_cnt, write_file, done, busy, sample_idx
    );
`endif
endinterface

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - read/convert/store/count/write sequencing controller for the conversion datapath
//
// Optional feature macro: CTRL_ABORT_EN (abort input on the bus; cancels a run back to IDLE).
//
// Parameters:
//   NUM_SAMPLES  samples per run, 1 .. 2**CNT_W
//   CALC_CYCLES  cycles spent converting each sample, >= 1
//   CNT_W        width of sample_idx
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   conv_seq_ctrl_if.slave: start/data_valid(/abort) in, one-hot Moore strobes,
//         done, busy and sample_idx out
//
// Every output is a register whose value is a pure function of the state
// register, so nothing on the bus depends combinationally on an input.
module conv_seq_ctrl #(
    parameter int NUM_SAMPLES = 24,
    parameter int CALC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic            clk,
    input  logic            rst,
    conv_seq_ctrl_if.slave  bus
);

    // A one-cycle CALC still needs a one-bit counter so the compare stays legal.
    localparam int WAIT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CALC_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_READ   = 3'd2,
        S_CALC   = 3'd3,
        S_STORE  = 3'd4,
        S_COUNT  = 3'd5,
        S_WRITE  = 3'd6,
        S_FINISH = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic [CNT_W-1:0]  idx_q,   idx_d;

    logic clr_q;
    logic read_data_q;
    logic store_num_q;
    logic en_cnt_q;
    logic write_file_q;
    logic done_q;
    logic busy_q;

    // Next-state, wait counter and sample index.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (bus.start) begin
                    state_d = S_ARMED;
                end
            end

            // The run launches on the falling edge of start, so hold here
            // for as long as start stays high.
            S_ARMED: begin
                if (!bus.start) begin
                    state_d = S_READ;
                end
            end

            S_READ: begin
                if (bus.data_valid) begin
                    state_d = S_CALC;
                    wait_d  = WAIT_LOAD;
                end
            end

            // wait_q counts the CALC cycles still to go after this one.
            S_CALC: begin
                if (wait_q == '0) begin
                    state_d = S_STORE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end

            S_STORE: begin
                state_d = S_COUNT;
            end

            // Terminal compare comes before the increment, so the index
            // never wraps even when NUM_SAMPLES == 2**CNT_W.
            S_COUNT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_WRITE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_READ;
                end
            end

            S_WRITE: begin
                state_d = S_FINISH;
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef CTRL_ABORT_EN
        // Cancel overrides every other transition, including COUNT -> WRITE.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            wait_d  = '0;
        end
`endif

        // The index reads zero for every cycle spent in IDLE, whichever way
        // IDLE was reached.
        if (state_d == S_IDLE) begin
            idx_d = '0;
        end
    end

    // State, counters and output registers. The strobes are decoded from
    // state_d so that each one lines up exactly with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wait_q       <= '0;
            idx_q        <= '0;
            clr_q        <= 1'b1;
            read_data_q  <= 1'b0;
            store_num_q  <= 1'b0;
            en_cnt_q     <= 1'b0;
            write_file_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            idx_q        <= idx_d;
            clr_q        <= (state_d == S_IDLE);
            read_data_q  <= (state_d == S_READ);
            store_num_q  <= (state_d == S_STORE);
            en_cnt_q     <= (state_d == S_COUNT);
            write_file_q <= (state_d == S_WRITE);
            done_q       <= (state_d == S_FINISH);
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign bus.clr        = clr_q;
    assign bus.read_data  = read_data_q;
    assign bus.store_num  = store_num_q;
    assign bus.en_cnt     = en_cnt_q;
    assign bus.write_file = write_file_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.sample_idx = idx_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - self-checking bench for conv_seq_ctrl over four parameter sets
module tb_conv_seq_ctrl;

    localparam int P_IDLE   = 0;
    localparam int P_ARMED  = 1;
    localparam int P_READ   = 2;
    localparam int P_CALC   = 3;
    localparam int P_STORE  = 4;
    localparam int P_COUNT  = 5;
    localparam int P_WRITE  = 6;
    localparam int P_FINISH = 7;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL u%0d %s got %0d want %0d at %0t", k, nm, act, exp, $time);
        end
    endtask

    // Four controllers: default, back-pressure, single sample, full-range index.
    for (genvar k = 0; k < 4; k++) begin : g
        localparam int NS = (k == 0) ? 24 : (k == 1) ? 4 : (k == 2) ? 1 : 8;
        localparam int CC = (k == 0) ? 1  : (k == 1) ? 3 : (k == 2) ? 1 : 2;
        localparam int CW = (k == 3) ? 3  : 8;

        conv_seq_ctrl_if #(.CNT_W(CW)) bus ();

        conv_seq_ctrl #(
            .NUM_SAMPLES (NS),
            .CALC_CYCLES (CC),
            .CNT_W       (CW)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Reference: current phase, CALC cycles left, current sample number.
        int ph   = P_IDLE;
        int idx  = 0;
        int left = 0;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                ph <= P_IDLE; idx <= 0; left <= 0;
            end
`ifdef CTRL_ABORT_EN
            else if (bus.abort && ph != P_IDLE) begin
                ph <= P_IDLE; idx <= 0;
            end
`endif
            else begin
                case (ph)
                    P_IDLE:   if (bus.start) ph <= P_ARMED;
                    P_ARMED:  if (!bus.start) ph <= P_READ;
                    P_READ:   if (bus.data_valid) begin ph <= P_CALC; left <= CC; end
                    P_CALC:   begin left <= left - 1; if (left == 1) ph <= P_STORE; end
                    P_STORE:  ph <= P_COUNT;
                    P_COUNT:  if (idx == NS - 1) ph <= P_WRITE;
                              else begin idx <= idx + 1; ph <= P_READ; end
                    P_WRITE:  ph <= P_FINISH;
                    default:  begin ph <= P_IDLE; idx <= 0; end
                endcase
            end
        end

        always @(negedge clk) begin
            chk(k, "clr",        bus.clr,        ph == P_IDLE);
            chk(k, "read_data",  bus.read_data,  ph == P_READ);
            chk(k, "store_num",  bus.store_num,  ph == P_STORE);
            chk(k, "en_cnt",     bus.en_cnt,     ph == P_COUNT);
            chk(k, "write_file", bus.write_file, ph == P_WRITE);
            chk(k, "done",       bus.done,       ph == P_FINISH);
            chk(k, "busy",       bus.busy,       ph != P_IDLE);
            chk(k, "sample_idx", 32'(bus.sample_idx), idx);
        end

        // Per-run tallies of observed strobes, cleared while armed.
        int n_read = 0, n_store = 0, n_cnt = 0, n_write = 0, n_done = 0;
        int rd_s1 = 0, max_idx = 0, first = -1, len = 0;

        always @(negedge clk) begin
            if (ph == P_ARMED) begin
                n_read <= 0; n_store <= 0; n_cnt <= 0; n_write <= 0; n_done <= 0;
                rd_s1 <= 0; max_idx <= 0; first <= -1; len <= 0;
            end else begin
                if (bus.read_data) begin
                    n_read <= n_read + 1;
                    if (first < 0) first <= cyc;
                    if (bus.sample_idx == 1) rd_s1 <= rd_s1 + 1;
                end
                if (bus.store_num)  n_store <= n_store + 1;
                if (bus.en_cnt)     n_cnt   <= n_cnt + 1;
                if (bus.write_file) n_write <= n_write + 1;
                if (bus.done) begin
                    n_done <= n_done + 1;
                    len    <= cyc - first + 1;
                end
                if (int'(bus.sample_idx) > max_idx) max_idx <= int'(bus.sample_idx);
            end
        end
    end

    function automatic int ph_of(input int k);
        case (k)
            0: return g[0].ph;
            1: return g[1].ph;
            2: return g[2].ph;
            default: return g[3].ph;
        endcase
    endfunction

    task automatic set_in(input int k, input logic s, input logic v);
        case (k)
            0: begin g[0].bus.start = s; g[0].bus.data_valid = v; end
            1: begin g[1].bus.start = s; g[1].bus.data_valid = v; end
            2: begin g[2].bus.start = s; g[2].bus.data_valid = v; end
            default: begin g[3].bus.start = s; g[3].bus.data_valid = v; end
        endcase
    endtask

`ifdef CTRL_ABORT_EN
    task automatic set_abort(input int k, input logic a);
        case (k)
            0: g[0].bus.abort = a;
            1: g[1].bus.abort = a;
            2: g[2].bus.abort = a;
            default: g[3].bus.abort = a;
        endcase
    endtask
`endif

    task automatic wait_ph(input int k, input int p, input int budget, input string nm);
        int n = 0;
        while (ph_of(k) != p && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(k, nm, ph_of(k) == p, 1);
    endtask

    task automatic run_full(input int k);
        set_in(k, 1'b1, 1'b1);
        @(negedge clk);
        set_in(k, 1'b0, 1'b1);
        wait_ph(k, P_READ, 10, "reach_read");
        wait_ph(k, P_IDLE, 400, "reach_end");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d", checks);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) set_in(k, 1'b0, 1'b0);
`ifdef CTRL_ABORT_EN
        for (int k = 0; k < 4; k++) set_abort(k, 1'b0);
`endif
        repeat (3) @(negedge clk);
        chk(0, "rst_clr",  g[0].bus.clr, 1);
        chk(0, "rst_busy", g[0].bus.busy, 0);
        chk(3, "rst_idx",  32'(g[3].bus.sample_idx), 0);
        rst = 1'b0;
        @(negedge clk);

        // Default run, data always valid.
        run_full(0);
        chk(0, "def_reads",  g[0].n_read, 24);
        chk(0, "def_stores", g[0].n_store, 24);
        chk(0, "def_counts", g[0].n_cnt, 24);
        chk(0, "def_writes", g[0].n_write, 1);
        chk(0, "def_dones",  g[0].n_done, 1);
        chk(0, "def_len",    g[0].len, 98);

        // start held for 10 cycles, then a stray start pulse mid-run.
        set_in(0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk(0, "held_read", g[0].bus.read_data, 0);
        chk(0, "held_busy", g[0].bus.busy, 1);
        set_in(0, 1'b0, 1'b1);
        repeat (30) @(negedge clk);
        set_in(0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        set_in(0, 1'b0, 1'b1);
        wait_ph(0, P_IDLE, 400, "stray_end");
        chk(0, "stray_reads", g[0].n_read, 24);
        chk(0, "stray_len",   g[0].len, 98);
        chk(0, "stray_dones", g[0].n_done, 1);

        // Back-pressure: five invalid cycles on the second sample.
        set_in(1, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1, 1'b0, 1'b1);
        n = 0;
        while (!(g[1].bus.read_data && g[1].bus.sample_idx == 1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(1, "bp_reach", g[1].bus.read_data, 1);
        set_in(1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        set_in(1, 1'b0, 1'b1);
        wait_ph(1, P_IDLE, 300, "bp_end");
        chk(1, "bp_rd_s1", g[1].rd_s1, 6);
        chk(1, "bp_reads", g[1].n_read, 9);
        chk(1, "bp_len",   g[1].len, 31);

        // Single-sample run.
        run_full(2);
        chk(2, "one_reads",  g[2].n_read, 1);
        chk(2, "one_stores", g[2].n_store, 1);
        chk(2, "one_counts", g[2].n_cnt, 1);
        chk(2, "one_writes", g[2].n_write, 1);
        chk(2, "one_max",    g[2].max_idx, 0);
        chk(2, "one_len",    g[2].len, 6);

        // Index range fully used: 8 samples on a 3-bit index.
        run_full(3);
        chk(3, "full_max",   g[3].max_idx, 7);
        chk(3, "full_reads", g[3].n_read, 8);
        chk(3, "full_dones", g[3].n_done, 1);
        chk(3, "full_len",   g[3].len, 42);

        // Reset in CALC of the third sample.
        set_in(1, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1, 1'b0, 1'b1);
        n = 0;
        while (!(ph_of(1) == P_CALC && g[1].idx == 2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(1, "mr_reach", ph_of(1) == P_CALC, 1);
        #2 rst = 1'b1;
        #1;
        chk(1, "mr_clr",   g[1].bus.clr, 1);
        chk(1, "mr_busy",  g[1].bus.busy, 0);
        chk(1, "mr_store", g[1].bus.store_num, 0);
        chk(1, "mr_idx",   32'(g[1].bus.sample_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk(1, "mr_writes", g[1].n_write, 0);
        chk(1, "mr_dones",  g[1].n_done, 0);

`ifdef CTRL_ABORT_EN
        // Abort in COUNT of the last sample, then a clean rerun.
        set_in(1, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1, 1'b0, 1'b1);
        n = 0;
        while (!(ph_of(1) == P_COUNT && g[1].idx == 3) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(1, "ab_reach", ph_of(1) == P_COUNT, 1);
        set_abort(1, 1'b1);
        @(negedge clk);
        set_abort(1, 1'b0);
        chk(1, "ab_clr", g[1].bus.clr, 1);
        chk(1, "ab_idx", 32'(g[1].bus.sample_idx), 0);
        repeat (5) @(negedge clk);
        chk(1, "ab_writes", g[1].n_write, 0);
        chk(1, "ab_dones",  g[1].n_done, 0);
        run_full(1);
        chk(1, "ab_rerun_len",   g[1].len, 26);
        chk(1, "ab_rerun_dones", g[1].n_done, 1);
`endif

        // Randomized traffic on all four controllers.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                set_in(k, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7);
`ifdef CTRL_ABORT_EN
                set_abort(k, $urandom_range(0, 99) == 0);
`endif
            end
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
